// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding, constants and sizing helper for the instruction loader
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        CHK  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int NB_DFLT        = 32;
    localparam int NB_BYTE_DFLT   = 8;
    localparam int BYTES_PER_WORD = NB_DFLT / NB_BYTE_DFLT;

    localparam logic [NB_DFLT-1:0] HALT_WORD = 32'hFFFF_FFFF;

    function automatic int idx_w(input int tam);
        return $clog2(tam);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// byte_packer: shifts bytes in big-endian order and pulses word_valid the cycle after a word completes
module byte_packer #(
    parameter int NB      = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               valid,
    input  logic [NB_BYTE-1:0] data,
    output logic               word_valid,
    output logic [NB-1:0]      word
);

    localparam int BPW = NB / NB_BYTE;
    localparam int CW  = $clog2(BPW);

    logic [CW-1:0] cnt;
    logic          full;

    assign full = cnt == CW'(BPW - 1);

    // shift register and byte counter; clear discards any partial word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= valid && full && !clear;
            if (clear) begin
                cnt <= '0;
            end else if (valid) begin
                cnt  <= full ? '0 : cnt + 1'b1;
                word <= {word[NB-NB_BYTE-1:0], data};
            end
        end
    end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: assembles UART bytes into words and writes them to instruction memory; LOADER_CHECKSUM_EN adds a trailing XOR check byte
module instr_loader
    import loader_pkg::*;
#(
    parameter int NB      = NB_DFLT,
    parameter int NB_BYTE = NB_BYTE_DFLT,
    parameter int TAM_I   = 256
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_instruction_write,
    output logic [NB-1:0]      o_instruction,
    output logic [NB-1:0]      o_address_memory_ins,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overflow,
    output logic               o_checksum_err
);

    localparam int IW = idx_w(TAM_I);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t HALT_NEXT = CHK;
`else
    localparam state_t HALT_NEXT = DONE;
`endif

    state_t          state, state_d;
    logic [IW-1:0]   idx;
    logic            word_valid;
    logic [NB-1:0]   word;
    logic            accept, strobe, is_halt, last;

    assign accept  = i_rx_valid && !i_start && state == RECV;
    assign strobe  = word_valid && state == RECV;
    assign is_halt = word == NB'(HALT_WORD);
    assign last    = idx == IW'(TAM_I - 1);

    byte_packer #(
        .NB      (NB),
        .NB_BYTE (NB_BYTE)
    ) u_packer (
        .clk        (i_clk),
        .rst_n      (i_reset),
        .clear      (i_start),
        .valid      (accept),
        .data       (i_rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // state register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_d;
    end

    // next state: start wins, then HALT or full memory ends the load
    always_comb begin
        state_d = state;
        if (i_start)
            state_d = RECV;
        else if (strobe && is_halt)
            state_d = HALT_NEXT;
        else if (strobe && last)
            state_d = DONE;
`ifdef LOADER_CHECKSUM_EN
        else if (state == CHK && i_rx_valid)
            state_d = DONE;
`endif
    end

    // word index and overflow flag; index saturates at the last word so the address never wraps
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            idx        <= '0;
            o_overflow <= 1'b0;
        end else if (i_start) begin
            idx        <= '0;
            o_overflow <= 1'b0;
        end else if (strobe) begin
            idx        <= last ? idx : idx + 1'b1;
            o_overflow <= o_overflow | (last && !is_halt);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [NB_BYTE-1:0] xsum;

    // running XOR of program bytes, compared against the byte that follows HALT
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            xsum           <= '0;
            o_checksum_err <= 1'b0;
        end else if (i_start) begin
            xsum           <= '0;
            o_checksum_err <= 1'b0;
        end else begin
            xsum           <= accept ? xsum ^ i_rx_data : xsum;
            o_checksum_err <= o_checksum_err | (state == CHK && i_rx_valid && i_rx_data != xsum);
        end
    end
`else
    assign o_checksum_err = 1'b0;
`endif

    // memory write port and status outputs; data/address read as zero outside the strobe
    always_comb begin
        o_instruction_write  = strobe;
        o_instruction        = strobe ? word : '0;
        o_address_memory_ins = strobe ? NB'({idx, 2'b00}) : '0;
        o_busy               = state == RECV || state == CHK;
        o_done               = state == DONE;
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed scoreboard bench for instr_loader (default depth and a 4-word instance)
module tb_instr_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        a_wr, a_busy, a_done, a_ovf, a_err;
    logic [31:0] a_data, a_addr;
    logic        b_wr, b_busy, b_done, b_ovf, b_err;
    logic [31:0] b_data, b_addr;

    exp_t q_a[$];
    exp_t q_b[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    instr_loader dut_a (
        .i_clk                (clk),
        .i_reset              (rst_n),
        .i_start              (start),
        .i_rx_data            (rx_data),
        .i_rx_valid           (rx_valid),
        .o_instruction_write  (a_wr),
        .o_instruction        (a_data),
        .o_address_memory_ins (a_addr),
        .o_busy               (a_busy),
        .o_done               (a_done),
        .o_overflow           (a_ovf),
        .o_checksum_err       (a_err)
    );

    instr_loader #(.TAM_I(4)) dut_b (
        .i_clk                (clk),
        .i_reset              (rst_n),
        .i_start              (start),
        .i_rx_data            (rx_data),
        .i_rx_valid           (rx_valid),
        .o_instruction_write  (b_wr),
        .o_instruction        (b_data),
        .o_address_memory_ins (b_addr),
        .o_busy               (b_busy),
        .o_done               (b_done),
        .o_overflow           (b_ovf),
        .o_checksum_err       (b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        exp_t e;
        if (a_wr) begin
            compared++;
            assert (q_a.size() != 0) else begin
                mismatched++;
                $error("FAIL strobe_a: observed write addr %h data %h expected none", a_addr, a_data);
            end
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                check("addr_a", a_addr, e.addr);
                check("data_a", a_data, e.data);
            end
        end
        if (b_wr) begin
            compared++;
            assert (q_b.size() != 0) else begin
                mismatched++;
                $error("FAIL strobe_b: observed write addr %h data %h expected none", b_addr, b_data);
            end
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                check("addr_b", b_addr, e.addr);
                check("data_b", b_data, e.data);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] addr, input logic [31:0] data, input bit to_b);
        exp_t e;
        e.addr = addr;
        e.data = data;
        q_a.push_back(e);
        if (to_b) q_b.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("rst_busy", 32'(a_busy), 0);
        check("rst_done", 32'(a_done), 0);
        check("rst_wr", 32'(a_wr), 0);

        // reset in the middle of a word, then stray bytes while idle
        pulse_start();
        send_byte(8'h12);
        send_byte(8'h34);
        check("load_busy", 32'(a_busy), 1);
        rst_n = 1'b0;
        #1;
        check("async_busy", 32'(a_busy), 0);
        check("async_ovf", 32'(a_ovf), 0);
        tick();
        rst_n = 1'b1;
        tick();
        send_word(32'h5678_9ABC);
        tick();
        check("idle_busy", 32'(a_busy), 0);
        check("idle_done", 32'(a_done), 0);
        check("idle_addr", a_addr, 0);
        check("idle_data", a_data, 0);

        // one word plus HALT
        pulse_start();
        push(32'd0, 32'h2001_0005, 1'b1);
        push(32'd4, 32'hFFFF_FFFF, 1'b1);
        send_word(32'h2001_0005);
        send_word(32'hFFFF_FFFF);
        check("halt_strobe_done", 32'(a_done), 0);
        tick();
`ifdef LOADER_CHECKSUM_EN
        check("chk_busy", 32'(a_busy), 1);
        send_byte(8'h24);
        check("chk_err0", 32'(a_err), 0);
`endif
        check("halt_done", 32'(a_done), 1);
        check("halt_busy", 32'(a_busy), 0);
        check("halt_ovf", 32'(a_ovf), 0);
        send_word(32'h0BAD_0BAD);
        tick();

        // fill memory of the 4-word instance with continuous bytes
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            push(32'(k * 4), {8'h10 + 8'(k), 8'h20, 8'h30, 8'h40 + 8'(k)}, 1'b1);
            send_word({8'h10 + 8'(k), 8'h20, 8'h30, 8'h40 + 8'(k)});
        end
        tick();
        check("full_done_b", 32'(b_done), 1);
        check("full_ovf_b", 32'(b_ovf), 1);
        check("full_busy_b", 32'(b_busy), 0);
        check("full_busy_a", 32'(a_busy), 1);
        check("full_ovf_a", 32'(a_ovf), 0);
        push(32'd16, 32'hC0DE_0004, 1'b0);
        send_word(32'hC0DE_0004);
        tick();
        check("full_ovf_b_hold", 32'(b_ovf), 1);

        // restart discards a partial word
        pulse_start();
        send_byte(8'h55);
        send_byte(8'h66);
        pulse_start();
        check("restart_ovf_b", 32'(b_ovf), 0);
        push(32'd0, 32'hAABB_CCDD, 1'b1);
        send_word(32'hAABB_CCDD);
        tick();

        // byte coincident with start is dropped
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h11;
        tick();
        start    = 1'b0;
        rx_valid = 1'b0;
        push(32'd0, 32'h0102_0304, 1'b1);
        send_word(32'h0102_0304);
        tick();

        // checksum program: 01 02 03 04 + HALT, XOR is 0x04
        pulse_start();
        push(32'd0, 32'h0102_0304, 1'b1);
        push(32'd4, 32'hFFFF_FFFF, 1'b1);
        send_word(32'h0102_0304);
        send_word(32'hFFFF_FFFF);
        tick();
`ifdef LOADER_CHECKSUM_EN
        check("cs_busy", 32'(a_busy), 1);
        check("cs_done_wait", 32'(a_done), 0);
        send_byte(8'h04);
        check("cs_done", 32'(a_done), 1);
        check("cs_err_ok", 32'(a_err), 0);
        pulse_start();
        push(32'd0, 32'h0102_0304, 1'b1);
        push(32'd4, 32'hFFFF_FFFF, 1'b1);
        send_word(32'h0102_0304);
        send_word(32'hFFFF_FFFF);
        tick();
        send_byte(8'h05);
        check("cs_err_bad", 32'(a_err), 1);
        check("cs_done_bad", 32'(a_done), 1);
        pulse_start();
        check("cs_err_clr", 32'(a_err), 0);
`else
        check("nocs_done", 32'(a_done), 1);
        check("nocs_busy", 32'(a_busy), 0);
        check("nocs_err", 32'(a_err), 0);
`endif

        repeat (3) tick();
        check("q_a_drained", 32'(q_a.size()), 0);
        check("q_b_drained", 32'(q_b.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
